// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: a small loadable instruction memory feeding an in-order
// fetch queue, with stall back-pressure, redirect/flush and a run/drain/done sequence.
module instr_fetch_queue #(
    parameter int IW = 16,
    parameter int AW = 4,
    parameter int QD = 4
) (
    input  logic          clk1,
    input  logic          rst_n,
    input  logic          ld_en,
    input  logic [AW-1:0] ld_addr,
    input  logic [IW-1:0] ld_data,
    input  logic [AW:0]   prog_len,
    input  logic          start,
    input  logic          redirect_en,
    input  logic [AW-1:0] redirect_pc,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [IW-1:0] out_instr,
    output logic [AW-1:0] out_pc,
    output logic          busy,
    output logic          done
);

    localparam int PW = $clog2(QD);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] QD_C = CW'(QD);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [IW-1:0] mem     [2**AW];
    logic [IW-1:0] q_instr [QD];
    logic [AW-1:0] q_pc    [QD];

    logic [1:0]    state_q, state_d;
    logic [AW:0]   pc_q, pc_d;
    logic [AW:0]   len_q, len_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic          push, pop, loadable;

    assign loadable  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign out_valid = (cnt_q != '0);
    assign pop       = out_valid && out_ready;
    // Gating the head by out_valid makes the outputs read zero the moment reset hits
    assign out_instr = out_valid ? q_instr[rd_q] : '0;
    assign out_pc    = out_valid ? q_pc[rd_q] : '0;
    assign busy      = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

    always_ff @(posedge clk1) begin
        if (ld_en && loadable) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk1) begin
        if (push) begin
            q_instr[wr_q] <= mem[pc_q[AW-1:0]];
            q_pc[wr_q]    <= pc_q[AW-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        push    = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    len_d   = prog_len;
                    pc_d    = '0;
                    cnt_d   = '0;
                    rd_d    = '0;
                    wr_d    = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH, S_DRAIN: begin
                if (redirect_en) begin
                    // Redirect wins over this cycle's push and pop; the flush discards both
                    cnt_d   = '0;
                    rd_d    = '0;
                    wr_d    = '0;
                    pc_d    = {1'b0, redirect_pc};
                    state_d = S_FETCH;
                end else begin
                    push = (state_q == S_FETCH) && (pc_q < len_q) && ((cnt_q < QD_C) || pop);
                    if (push) begin
                        wr_d = wr_q + PW'(1);
                        pc_d = pc_q + (AW+1)'(1);
                    end
                    if (pop) begin
                        rd_d = rd_q + PW'(1);
                    end
                    case ({push, pop})
                        2'b10:   cnt_d = cnt_q + CW'(1);
                        2'b01:   cnt_d = cnt_q - CW'(1);
                        default: cnt_d = cnt_q;
                    endcase
                    if (state_q == S_FETCH) begin
                        if (pc_d >= len_q) begin
                            state_d = S_DRAIN;
                        end
                    end else if (cnt_q == '0) begin
                        state_d = S_DONE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
        end
    end

endmodule
